// File: rtl/time_set_controller.sv
// time_set_controller: front-panel editor for the 15-bit current-time word.
// Build with SET_TIMEOUT_EN defined to add an idle auto-abort from the SET states.
module time_set_controller #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TO_W           = 10
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Mode_Btn,
    input  logic        Inc_Btn,
    input  logic        Dec_Btn,
    input  logic        Cancel_Btn,
    input  logic [14:0] CTO_In,
    output logic [14:0] CTI,
    output logic        LD,
    output logic        Enable,
    output logic        Setting,
    output logic [1:0]  Field_Sel
);

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_DAY  = 3'd1,
        SET_HOUR = 3'd2,
        SET_MT   = 3'd3,
        SET_MU   = 3'd4,
        COMMIT   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [14:0] edit_q, edit_d;
    logic [3:0]  btn_prev_q, btn_prev_d;

    logic [3:0]  btn_now;
    logic [3:0]  press;
    logic        mode_press, inc_press, dec_press, cancel_press;
    logic        any_press;
    logic        in_set;

    logic [4:0]  field_cur;
    logic [4:0]  field_max;
    logic [4:0]  field_new;
    logic [14:0] edit_upd;

    // Out-of-range values (e.g. hour 25 read back) land on 0 for Inc and max for Dec.
    function automatic logic [4:0] wrap_inc(input logic [4:0] v, input logic [4:0] max_v);
        return (v >= max_v) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [4:0] wrap_dec(input logic [4:0] v, input logic [4:0] max_v);
        return ((v == 5'd0) || (v > max_v)) ? max_v : v - 5'd1;
    endfunction

    assign btn_now      = {Mode_Btn, Inc_Btn, Dec_Btn, Cancel_Btn};
    assign press        = btn_now & ~btn_prev_q;
    assign mode_press   = press[3];
    assign inc_press    = press[2];
    assign dec_press    = press[1];
    assign cancel_press = press[0];
    assign any_press    = |press;
    assign in_set       = state_q inside {SET_DAY, SET_HOUR, SET_MT, SET_MU};

    always_comb begin
        btn_prev_d = btn_now;
    end

    always_comb begin
        field_cur = 5'd0;
        field_max = 5'd0;
        case (state_q)
            SET_DAY: begin
                field_cur = {2'b00, edit_q[14:12]};
                field_max = 5'd6;
            end
            SET_HOUR: begin
                field_cur = edit_q[11:7];
                field_max = 5'd23;
            end
            SET_MT: begin
                field_cur = {2'b00, edit_q[6:4]};
                field_max = 5'd5;
            end
            SET_MU: begin
                field_cur = {1'b0, edit_q[3:0]};
                field_max = 5'd9;
            end
            default: ;
        endcase
    end

    always_comb begin
        field_new = inc_press ? wrap_inc(field_cur, field_max)
                              : wrap_dec(field_cur, field_max);
    end

    // Splice the new field value back in; all other bits of the edit word hold.
    always_comb begin
        edit_upd = edit_q;
        case (state_q)
            SET_DAY:  edit_upd[14:12] = field_new[2:0];
            SET_HOUR: edit_upd[11:7]  = field_new;
            SET_MT:   edit_upd[6:4]   = field_new[2:0];
            SET_MU:   edit_upd[3:0]   = field_new[3:0];
            default: ;
        endcase
    end

`ifdef SET_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_hit;

    assign timeout_hit = in_set && !any_press && (to_cnt_q == TO_LAST);

    // Entry into a SET state always comes with a press, so clearing on a press covers it.
    always_comb begin
        to_cnt_d = '0;
        if (in_set && !any_press && !timeout_hit) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    if ((TIMEOUT_CYCLES >> TO_W) != 0) begin : g_timeout_cfg_unused
    end
`endif

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state_q    <= RUN;
            edit_q     <= '0;
            btn_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            edit_q     <= edit_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    // Press priority inside a SET state: Cancel, then Mode, then a lone Inc or Dec.
    always_comb begin
        state_d = state_q;
        edit_d  = edit_q;
        case (state_q)
            RUN: begin
                if (mode_press) begin
                    state_d = SET_DAY;
                    edit_d  = CTO_In;
                end
            end
            SET_DAY, SET_HOUR, SET_MT, SET_MU: begin
                if (cancel_press) begin
                    state_d = RUN;
                end else if (mode_press) begin
                    case (state_q)
                        SET_DAY:  state_d = SET_HOUR;
                        SET_HOUR: state_d = SET_MT;
                        SET_MT:   state_d = SET_MU;
                        default:  state_d = COMMIT;
                    endcase
                end else if (inc_press ^ dec_press) begin
                    edit_d = edit_upd;
                end
`ifdef SET_TIMEOUT_EN
                if (timeout_hit) begin
                    state_d = RUN;
                end
`endif
            end
            COMMIT: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_comb begin
        LD        = 1'b0;
        Enable    = 1'b0;
        Setting   = 1'b0;
        Field_Sel = 2'd0;
        case (state_q)
            RUN: begin
                Enable = 1'b1;
            end
            SET_DAY: begin
                Setting   = 1'b1;
                Field_Sel = 2'd0;
            end
            SET_HOUR: begin
                Setting   = 1'b1;
                Field_Sel = 2'd1;
            end
            SET_MT: begin
                Setting   = 1'b1;
                Field_Sel = 2'd2;
            end
            SET_MU: begin
                Setting   = 1'b1;
                Field_Sel = 2'd3;
            end
            COMMIT: begin
                LD = 1'b1;
            end
            default: begin
                Enable = 1'b1;
            end
        endcase
    end

    assign CTI = edit_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller; each step is checked with an immediate assertion.
// The timeout section is compiled in when SET_TIMEOUT_EN is defined.
module tb_time_set_controller;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic        Mode_Btn = 1'b0;
    logic        Inc_Btn = 1'b0;
    logic        Dec_Btn = 1'b0;
    logic        Cancel_Btn = 1'b0;
    logic [14:0] CTO_In = '0;
    logic [14:0] CTI;
    logic        LD;
    logic        Enable;
    logic        Setting;
    logic [1:0]  Field_Sel;

    int checks = 0;
    int errors = 0;
    int ld_cycles = 0;

`ifdef SET_TIMEOUT_EN
    localparam int HOLD_CYCLES = 12;
`else
    localparam int HOLD_CYCLES = 20;
`endif

    time_set_controller #(
        .TIMEOUT_CYCLES(16),
        .TO_W(5)
    ) dut (
        .Clock(Clock),
        .Clear(Clear),
        .Mode_Btn(Mode_Btn),
        .Inc_Btn(Inc_Btn),
        .Dec_Btn(Dec_Btn),
        .Cancel_Btn(Cancel_Btn),
        .CTO_In(CTO_In),
        .CTI(CTI),
        .LD(LD),
        .Enable(Enable),
        .Setting(Setting),
        .Field_Sel(Field_Sel)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (LD === 1'b1) ld_cycles++;
    end

    function automatic logic [14:0] statusWord(input logic ld, input logic en,
                                               input logic set, input logic [1:0] fs);
        return {10'd0, ld, en, set, fs};
    endfunction

    task automatic applyStimulus(input logic m, input logic i, input logic d, input logic c);
        Mode_Btn   = m;
        Inc_Btn    = i;
        Dec_Btn    = d;
        Cancel_Btn = c;
        @(posedge Clock);
        #1;
    endtask

    task automatic pulse(input logic m, input logic i, input logic d, input logic c);
        applyStimulus(m, i, d, c);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [14:0] observed,
                               input logic [14:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
        end
    endtask

    initial begin
        $display("[TB] reset with buttons toggling");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        Clear = 1'b1;
        checkOutput("reset_status", statusWord(LD, Enable, Setting, Field_Sel), statusWord(1'b0, 1'b1, 1'b0, 2'd0));
        checkOutput("reset_cti", CTI, 15'd0);
        CTO_In = 15'b010_01000_100_0011;
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("run_inc_ignored_cti", CTI, 15'd0);
        checkOutput("run_inc_ignored_status", statusWord(LD, Enable, Setting, Field_Sel), statusWord(1'b0, 1'b1, 1'b0, 2'd0));

        $display("[TB] full set sequence");
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("enter_day_status", statusWord(LD, Enable, Setting, Field_Sel), statusWord(1'b0, 1'b0, 1'b1, 2'd0));
        checkOutput("enter_day_cti", CTI, 15'b010_01000_100_0011);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("day_inc", CTI, 15'b011_01000_100_0011);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("hour_status", statusWord(LD, Enable, Setting, Field_Sel), statusWord(1'b0, 1'b0, 1'b1, 2'd1));
        for (int k = 0; k < 8; k++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("hour_dec8", CTI, 15'b011_00000_100_0011);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("hour_dec_wrap", CTI, 15'b011_10111_100_0011);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("mt_status", statusWord(LD, Enable, Setting, Field_Sel), statusWord(1'b0, 1'b0, 1'b1, 2'd2));
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("mu_status", statusWord(LD, Enable, Setting, Field_Sel), statusWord(1'b0, 1'b0, 1'b1, 2'd3));
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("mu_inc", CTI, 15'b011_10111_100_0100);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("commit_status", statusWord(LD, Enable, Setting, Field_Sel), statusWord(1'b1, 1'b0, 1'b0, 2'd0));
        checkOutput("commit_cti", CTI, 15'b011_10111_100_0100);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("after_commit_status", statusWord(LD, Enable, Setting, Field_Sel), statusWord(1'b0, 1'b1, 1'b0, 2'd0));
        checkOutput("after_commit_cti", CTI, 15'b011_10111_100_0100);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ld_once", 15'(ld_cycles), 15'd1);

        $display("[TB] wrap cases");
        CTO_In = 15'b000_00101_010_1001;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("day_dec_wrap", CTI, 15'b110_00101_010_1001);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_mu_status", statusWord(LD, Enable, Setting, Field_Sel), statusWord(1'b0, 1'b0, 1'b1, 2'd3));
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("mu_inc_wrap", CTI, 15'b110_00101_010_0000);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("wrap_cancel_status", statusWord(LD, Enable, Setting, Field_Sel), statusWord(1'b0, 1'b1, 1'b0, 2'd0));
        checkOutput("wrap_cancel_cti", CTI, 15'b110_00101_010_0000);

        $display("[TB] out-of-range fields");
        CTO_In = 15'b001_11001_111_1111;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("hour25_inc", CTI, 15'b001_00000_111_1111);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("mt7_dec", CTI, 15'b001_00000_101_1111);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("mu15_inc", CTI, 15'b001_00000_101_0000);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("mu0_dec_wrap", CTI, 15'b001_00000_101_1001);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] cancel");
        CTO_In = 15'b100_00001_001_0001;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("cancel_pre_cti", CTI, 15'b110_00001_001_0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("cancel_status", statusWord(LD, Enable, Setting, Field_Sel), statusWord(1'b0, 1'b1, 1'b0, 2'd0));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("cancel_cti_kept", CTI, 15'b110_00001_001_0001);
        checkOutput("cancel_no_ld", 15'(ld_cycles), 15'd1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("reenter_cti", CTI, 15'b100_00001_001_0001);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("cancel_beats_mode", statusWord(LD, Enable, Setting, Field_Sel), statusWord(1'b0, 1'b1, 1'b0, 2'd0));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] held and simultaneous buttons");
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("mode_beats_inc_status", statusWord(LD, Enable, Setting, Field_Sel), statusWord(1'b0, 1'b0, 1'b1, 2'd1));
        checkOutput("mode_beats_inc_cti", CTI, 15'b100_00001_001_0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < HOLD_CYCLES; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("held_inc_once", CTI, 15'b100_00010_001_0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("inc_dec_together", CTI, 15'b100_00010_001_0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("hour_dec", CTI, 15'b100_00001_001_0001);
`ifndef SET_TIMEOUT_EN
        for (int k = 0; k < 40; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("set_persists", statusWord(LD, Enable, Setting, Field_Sel), statusWord(1'b0, 1'b0, 1'b1, 2'd1));
`endif

        $display("[TB] reset mid-edit");
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("pre_reset_cti", CTI, 15'b100_00010_001_0001);
        Clear = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        Clear = 1'b1;
        checkOutput("midreset_status", statusWord(LD, Enable, Setting, Field_Sel), statusWord(1'b0, 1'b1, 1'b0, 2'd0));
        checkOutput("midreset_cti", CTI, 15'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("midreset_no_ld", 15'(ld_cycles), 15'd1);

`ifdef SET_TIMEOUT_EN
        $display("[TB] idle timeout");
        CTO_In = 15'b001_00100_011_0101;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 15; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("timeout_not_yet", statusWord(LD, Enable, Setting, Field_Sel), statusWord(1'b0, 1'b0, 1'b1, 2'd1));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("timeout_abort", statusWord(LD, Enable, Setting, Field_Sel), statusWord(1'b0, 1'b1, 1'b0, 2'd0));
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 15; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("timeout_delayed", statusWord(LD, Enable, Setting, Field_Sel), statusWord(1'b0, 1'b0, 1'b1, 2'd1));
        checkOutput("timeout_press_cti", CTI, 15'b001_00101_011_0101);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("timeout_delayed_abort", statusWord(LD, Enable, Setting, Field_Sel), statusWord(1'b0, 1'b1, 1'b0, 2'd0));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("timeout_no_ld", 15'(ld_cycles), 15'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Sequences user edits of the current-time register.
- Button presses select a field (day, hour, minute-tens, minute-units), then increment or decrement it with wrap.
- On commit, the edited value is written into the current-time register through a one-cycle LD pulse.
- Sits between the front-panel button logic and current_time_module, and drives its CTI, LD and Enable inputs.
- Time word layout: [14:12] day 0-6, [11:7] hour 0-23, [6:4] minute tens 0-5, [3:0] minute units 0-9.

Parameters:
- TIMEOUT_CYCLES, 1000: idle cycles in a SET state before auto-abort. Used only with SET_TIMEOUT_EN.
- TO_W, 10: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- Clock  in  1  system clock; all logic updates on the rising edge.
- Clear  in  1  reset, synchronous and active-low.
- Mode_Btn  in  1  level input; a rising edge enters set mode, advances the field, or commits.
- Inc_Btn  in  1  level input; a rising edge increments the selected field.
- Dec_Btn  in  1  level input; a rising edge decrements the selected field.
- Cancel_Btn  in  1  level input; a rising edge aborts an edit.
- CTO_In  in  15  current time read back from current_time_module.
- CTI  out  15  edit value, driven to current_time_module CTI.
- LD  out  1  load strobe to current_time_module.
- Enable  out  1  count enable to current_time_module.
- Setting  out  1  high while in any SET state.
- Field_Sel  out  2  selected field: 0 day, 1 hour, 2 min-tens, 3 min-units.

Behaviour:
- Reset:
  - Clear=0 at an edge forces state RUN.
  - After that edge: edit register 0, CTI=0, LD=0, Enable=1, Setting=0, Field_Sel=0.
  - Button history registers are cleared.
  - Reset mid-edit discards the edit; no LD is issued.
- Press detection:
  - Per button, press = btn & ~btn_prev, where btn_prev is registered every edge.
  - A press is acted on at the same edge, so the response is visible 1 cycle after the button level rises.
  - A held button produces exactly one press.
- States: RUN, SET_DAY, SET_HOUR, SET_MT, SET_MU, COMMIT.
- RUN:
  - Enable=1, LD=0.
  - Mode press: edit <= CTO_In, Enable <= 0, go to SET_DAY.
  - Inc, Dec and Cancel are ignored.
- SET_DAY, SET_HOUR, SET_MT, SET_MU:
  - Enable=0, Setting=1, Field_Sel = 0/1/2/3 respectively.
  - Mode press advances DAY->HOUR->MT->MU->COMMIT.
  - Inc press: field+1, wrapping max->0 (day 6->0, hour 23->0, MT 5->0, MU 9->0).
  - Dec press: field-1, wrapping 0->max.
  - A field value out of range (e.g. hour 25 loaded from CTO_In) goes to 0 on Inc and to max on Dec.
  - Only the selected field changes; the other bits of the edit register hold.
- Press priority within one cycle: Cancel > Mode > Inc/Dec.
  - Cancel goes to RUN with Enable=1 and no LD; the edit register is kept but not loaded.
  - Inc and Dec pressed in the same cycle: no change.
- COMMIT:
  - Lasts exactly 1 cycle.
  - LD=1, CTI=edit, Enable=0.
  - Next edge: RUN, LD=0, Enable=1.
  - All presses during COMMIT are ignored.
- CTI always reflects the edit register, including while in RUN.
- LD is 1 only in COMMIT.

Optional Feature:
- Macro SET_TIMEOUT_EN.
- Defined:
  - A TO_W-bit idle counter clears on entry to any SET state and on any press.
  - It increments each cycle while in a SET state.
  - When it reaches TIMEOUT_CYCLES-1, the next edge goes to RUN with Enable=1 and no LD.
- Undefined: no counter is built; SET states persist indefinitely.

Test Plan:
- Reset: Clear=0 for 2 edges with buttons toggling -> LD=0, Enable=1, CTI=0, state RUN; Inc press in RUN -> CTI stays 0.
- Full set: CTO_In=15'b010_01000_100_0011 (day 2, 08:43); Mode, Inc, Mode, Dec×9, Mode, Mode, Inc, Mode -> exactly one LD cycle with CTI = day 3, hour 23, min 44, i.e. 15'b011_10111_100_0100; Enable returns to 1 the cycle after LD.
- Wrap: in SET_MU with MU=9, Inc -> 0 and MT unchanged; in SET_DAY with day=0, Dec -> 6.
- Cancel: enter set, Inc twice, Cancel -> no LD pulse, Enable=1 next cycle; Cancel and Mode in the same cycle -> RUN.
- Held/simultaneous: Inc held high 20 cycles -> +1 only; Inc and Dec rising together -> field unchanged.
- Timeout (SET_TIMEOUT_EN, TIMEOUT_CYCLES=16): enter SET_HOUR, idle 16 cycles -> RUN, LD never asserted; a press at cycle 10 delays the abort by 11 cycles.
